// File: rtl/zbt_pkg.sv
// Shared types and widths for the ZBT write path.
package zbt_pkg;
  localparam int ZBT_ADDR_W = 19;
  localparam int ZBT_DATA_W = 36;
  localparam int PIX_W      = 8;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} wr_state_e;

  typedef struct packed {
    logic [ZBT_ADDR_W-1:0] addr;
    logic [ZBT_DATA_W-1:0] data;
  } zbt_wr_t;
endpackage

// File: rtl/pixel_to_zbt_writer_if.sv
// ZBT write-bus: slot grant from display timing in, one-cycle write strobe out.
interface pixel_to_zbt_writer_if;
  import zbt_pkg::*;
  logic                  write_slot;
  logic                  zbt_we;
  logic [ZBT_ADDR_W-1:0] zbt_write_addr;
  logic [ZBT_DATA_W-1:0] zbt_write_data;

  modport master (input write_slot, output zbt_we, zbt_write_addr, zbt_write_data);
  modport slave  (output write_slot, input zbt_we, zbt_write_addr, zbt_write_data);
endinterface

// File: rtl/zbt_write_fifo.sv
// Small sync FIFO of {addr,data} entries; head comes straight from the storage flops.
module zbt_write_fifo import zbt_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  zbt_wr_t                wdata,
  output zbt_wr_t                head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  zbt_wr_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  // A push into a full FIFO still lands when the same cycle pops.
  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    do_push  = push && ((cnt_q != (AW+1)'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign count = cnt_q;
endmodule

// File: rtl/pixel_to_zbt_writer.sv
// Packs 4 pixels per ZBT word at a raster address and issues queued writes in granted bus slots.
module pixel_to_zbt_writer import zbt_pkg::*; #(
  parameter int                    H_PIXELS   = 640,
  parameter int                    V_LINES    = 480,
  parameter logic [ZBT_ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  line_start,
  input  logic                  pix_valid,
  input  logic [PIX_W-1:0]      pix_data,
  pixel_to_zbt_writer_if.master bus,
  output logic                  frame_done,
  output logic                  overflow
);
  localparam int WPL = H_PIXELS / 4;

  wr_state_e             state_q, state_d;
  logic [ZBT_ADDR_W-1:0] row_q, row_d, col_q, col_d;
  logic [1:0]            idx_q, idx_d;
  logic [ZBT_DATA_W-1:0] word_q, word_d;
  logic                  first_q, first_d;
  logic                  done_q, done_d, ovf_q, ovf_d;
  zbt_wr_t               last_q, last_d;

  zbt_wr_t                    push_ent, head;
  logic                       push, pop, drop, pix_ok;
  logic                       fifo_empty, fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

  assign pop      = bus.write_slot && !fifo_empty;
  assign drop     = push && fifo_full && !pop;
  assign push_ent = '{addr: BASE_ADDR + row_q * ZBT_ADDR_W'(WPL) + col_q, data: word_d};

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    idx_d   = idx_q;
    word_d  = word_q;
    first_d = first_q;
    done_d  = 1'b0;
    push    = 1'b0;
    last_d  = pop ? head : last_q;
    ovf_d   = (frame_start ? 1'b0 : ovf_q) | drop;
    pix_ok  = (state_q == CAPTURE) && pix_valid && !line_start && !frame_start &&
              (row_q < ZBT_ADDR_W'(V_LINES)) && (col_q < ZBT_ADDR_W'(WPL));

    if (pix_ok) begin
      word_d[ZBT_DATA_W-1 - 9*int'(idx_q) -: 9] = {pix_data, 1'b0};
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        push  = 1'b1;
        col_d = col_q + 1'b1;
        if (row_q == ZBT_ADDR_W'(V_LINES-1) && col_q == ZBT_ADDR_W'(WPL-1)) state_d = DRAIN;
      end
    end

    // The first line_start after frame_start opens row 0 rather than advancing.
    if (state_q == CAPTURE && line_start && !frame_start) begin
      if (first_q) first_d = 1'b0;
      else if (row_q < ZBT_ADDR_W'(V_LINES)) row_d = row_q + 1'b1;
      col_d = '0;
      idx_d = '0;
    end

    if (state_q == DRAIN && !frame_start) begin
      if (fifo_empty) state_d = IDLE;
      else if (pop && fifo_cnt == 1) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end

    if (frame_start) begin
      state_d = CAPTURE;
      row_d   = '0;
      col_d   = '0;
      idx_d   = '0;
      first_d = !line_start;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      first_q <= first_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
    end
  end

  zbt_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (push_ent),
    .head  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_cnt)
  );

  // Address/data follow the FIFO head only while writing, otherwise hold the last write.
  assign bus.zbt_we         = pop;
  assign bus.zbt_write_addr = pop ? head.addr : last_q.addr;
  assign bus.zbt_write_data = pop ? head.data : last_q.data;
  assign frame_done         = done_q;
  assign overflow           = ovf_q;
endmodule
